fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage and IF/ID pipeline register of the 5-stage MIPS core.
- Owns the PC, addresses the combinational instruction ROM, and registers the fetched instruction into the ID stage.
- Consumes the registered `stall` from the decode-stage stall controller, plus the `flush` and redirect controls from branch/jump resolution.
- Its `id_instr` output is the instruction the stall controller inspects.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded at reset (word aligned).
- IMEM_AW, 10, instruction ROM word-address width.
- CNT_W, 32, width of the fetched-instruction counter.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- stall  in  1  hold PC and IF/ID contents this cycle.
- flush  in  1  load a bubble into IF/ID this cycle.
- redirect_en  in  1  load PC from redirect_target (taken branch, j, jal, jr).
- redirect_target  in  32  new PC; bits [1:0] ignored and forced to 0.
- imem_addr  out  IMEM_AW  ROM word address, equal to pc[IMEM_AW+1:2] (combinational).
- imem_rdata  in  32  ROM data for imem_addr, valid in the same cycle.
- if_pc  out  32  current PC register.
- id_instr  out  32  IF/ID instruction.
- id_pc  out  32  PC of id_instr.
- id_pc4  out  32  id_pc + 4.
- id_valid  out  1  1 = id_instr is a real instruction; 0 = bubble.
- fetch_cnt  out  CNT_W  number of real instructions loaded into IF/ID.

Behaviour:
- Reset (rst=0, asynchronous):
  - pc = RESET_PC.
  - id_instr = 32'h0000_0000 (NOP, sll $0,$0,0).
  - id_pc = 0, id_pc4 = 0, id_valid = 0, fetch_cnt = 0.
- Reset release: the first edge with rst=1 performs a normal fetch from RESET_PC.
- Reset asserted mid-operation: all state returns to reset values immediately. No pending redirect survives reset.
- PC next-state, evaluated in priority order each cycle:
  1. redirect_en=1 -> pc <= {redirect_target[31:2], 2'b00}. This applies even when stall=1.
  2. stall=1 -> pc holds.
  3. Otherwise -> pc <= pc + 4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
- IF/ID next-state, evaluated in priority order each cycle:
  1. flush=1 or redirect_en=1 -> id_instr <= 0, id_valid <= 0. id_pc and id_pc4 hold.
  2. stall=1 -> all IF/ID fields hold, including id_valid.
  3. Otherwise -> id_instr <= imem_rdata, id_pc <= pc, id_pc4 <= pc + 4, id_valid <= 1.
- Simultaneous stall+flush with no redirect: PC holds and IF/ID takes a bubble.
- Latency:
  - An instruction at address A appears on id_instr exactly one edge after pc == A with stall=0 and no flush/redirect.
  - After a redirect at edge E, the target instruction is on id_instr at edge E+1 (one bubble in between).
- fetch_cnt: increments by 1 on every edge where IF/ID loads per IF/ID rule 3. Wraps modulo 2^CNT_W. Otherwise holds.
- imem_addr is purely combinational from pc. No other output is combinational.
- Out-of-range pc (bits above IMEM_AW+1) is silently truncated on imem_addr.
- No X is ever propagated from the stall/flush/redirect inputs: inputs are assumed 0/1, and the bench checks for X on them.

Decomposition:
- Shared package mips_pkg:
  - NOP_INSTR = 32'h0000_0000.
  - INSTR_W = 32.
  - PC_STEP = 4.
  - Opcode localparams, also needed by the stall controller and decoder.
- One natural sub-module, pc_reg: PC register with redirect/stall/increment priority mux and reset to RESET_PC.
- The IF/ID register and counter stay in fetch_stage.

Test Plan:
- Reset with RESET_PC = 32'h3000, ROM[0] = 32'h2008_0005, ROM[1] = 32'h2009_0003; release rst, no controls:
  - edge 1: id_instr = 32'h2008_0005, id_pc = 32'h3000, id_pc4 = 32'h3004, id_valid = 1.
  - edge 2: id_pc = 32'h3004.
  - fetch_cnt = 2.
- Branch in ID: ROM word at 32'h3008 = 32'h1109_0002 (beq); hold stall=1 for one cycle after it lands:
  - pc stays at 32'h300C for that edge.
  - id_instr keeps its value.
  - fetch_cnt does not increment.
- Redirect with stall: redirect_en=1, stall=1, target = 32'h3022:
  - pc = 32'h3020 next edge.
  - id_valid = 0, id_instr = 0.
  - Following edge: id_pc = 32'h3020, id_valid = 1.
- Flush only (flush=1, stall=0):
  - pc advances by 4.
  - id_valid = 0, id_instr = 0.
  - fetch_cnt unchanged.
- Wrap-around:
  - Force redirect to 32'hFFFF_FFFC; after next normal edge pc = 32'h0000_0000.
  - With CNT_W = 4, 16 fetches return fetch_cnt to 0.
- Asynchronous reset mid-stream: pull rst low between edges while stall=1:
  - Outputs go to reset values without a clock edge.
  - pc = RESET_PC immediately.
  - On release, normal fetch resumes from 32'h3000.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS core constants: instruction width, PC step, NOP encoding and opcodes.
package mips_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam logic [31:0] PC_STEP = 32'd4;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

    // Primary opcode field values used by fetch, decode and the stall controller.
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

endpackage

// File: rtl/pc_reg.sv
// Program counter: redirect beats stall beats sequential increment.
module pc_reg
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        stall_i,
    input  logic        redirect_en_i,
    input  logic [31:0] redirect_target_i,
    output logic [31:0] pc_o
);

    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [31:0] target_aligned;

    // Low two target bits are forced to zero so the PC stays word aligned.
    assign target_aligned = redirect_target_i & 32'hFFFF_FFFC;

    always_comb begin
        pc_d = pc_q;
        if (redirect_en_i) begin
            pc_d = target_aligned;
        end else if (!stall_i) begin
            pc_d = pc_q + PC_STEP;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, addresses the instruction ROM and holds the IF/ID register.
module fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int unsigned IMEM_AW  = 10,
    parameter int unsigned CNT_W    = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               flush,
    input  logic               redirect_en,
    input  logic [31:0]        redirect_target,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_rdata,
    output logic [31:0]        if_pc,
    output logic [31:0]        id_instr,
    output logic [31:0]        id_pc,
    output logic [31:0]        id_pc4,
    output logic               id_valid,
    output logic [CNT_W-1:0]   fetch_cnt
);

    logic [31:0] pc;

    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [31:0]        id_pc_q, id_pc_d;
    logic [31:0]        id_pc4_q, id_pc4_d;
    logic               valid_q, valid_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               load;

    pc_reg #(
        .RESET_PC(RESET_PC)
    ) u_pc_reg (
        .clk_i            (clk),
        .rst_ni           (rst),
        .stall_i          (stall),
        .redirect_en_i    (redirect_en),
        .redirect_target_i(redirect_target),
        .pc_o             (pc)
    );

    // ROM index silently drops PC bits above the ROM's address range.
    assign imem_addr = pc[IMEM_AW+1:2];

    // IF/ID next state: a kill (flush or redirect) wins over stall; PC fields hold on a kill.
    always_comb begin
        instr_d  = instr_q;
        id_pc_d  = id_pc_q;
        id_pc4_d = id_pc4_q;
        valid_d  = valid_q;
        load     = 1'b0;
        if (flush || redirect_en) begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end else if (!stall) begin
            instr_d  = imem_rdata;
            id_pc_d  = pc;
            id_pc4_d = pc + PC_STEP;
            valid_d  = 1'b1;
            load     = 1'b1;
        end
    end

    assign cnt_d = load ? cnt_q + CNT_W'(1) : cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instr_q  <= NOP_INSTR;
            id_pc_q  <= 32'h0000_0000;
            id_pc4_q <= 32'h0000_0000;
            valid_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            instr_q  <= instr_d;
            id_pc_q  <= id_pc_d;
            id_pc4_q <= id_pc4_d;
            valid_q  <= valid_d;
            cnt_q    <= cnt_d;
        end
    end

    assign if_pc     = pc;
    assign id_instr  = instr_q;
    assign id_pc     = id_pc_q;
    assign id_pc4    = id_pc4_q;
    assign id_valid  = valid_q;
    assign fetch_cnt = cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed literal checks plus randomized control traffic against a behavioural model.
module tb_fetch_stage;

    localparam int unsigned AW = 10;
    localparam int unsigned CW = 4;
    localparam logic [31:0] RPC = 32'h0000_3000;

    logic          clk = 1'b0;
    logic          rst;
    logic          stall, flush, redirect_en;
    logic [31:0]   redirect_target;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_rdata;
    logic [31:0]   if_pc, id_instr, id_pc, id_pc4;
    logic          id_valid;
    logic [CW-1:0] fetch_cnt;

    logic [31:0] rom [0:(1<<AW)-1];

    int n_tests = 0;
    int n_fail  = 0;
    logic cmp_en = 1'b0;

    // Behavioural reference state
    logic [31:0]   m_pc, m_instr, m_idpc, m_idpc4;
    logic          m_valid;
    logic [CW-1:0] m_cnt;

    fetch_stage #(
        .RESET_PC(RPC),
        .IMEM_AW (AW),
        .CNT_W   (CW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .flush          (flush),
        .redirect_en    (redirect_en),
        .redirect_target(redirect_target),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .if_pc          (if_pc),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .id_pc4         (id_pc4),
        .id_valid       (id_valid),
        .fetch_cnt      (fetch_cnt)
    );

    always #5 clk = ~clk;

    assign imem_rdata = rom[imem_addr];

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_pc    <= RPC;
            m_instr <= 32'h0;
            m_idpc  <= 32'h0;
            m_idpc4 <= 32'h0;
            m_valid <= 1'b0;
            m_cnt   <= '0;
        end else begin
            if (redirect_en)  m_pc <= {redirect_target[31:2], 2'b00};
            else if (!stall)  m_pc <= m_pc + 32'd4;
            if (flush || redirect_en) begin
                m_instr <= 32'h0;
                m_valid <= 1'b0;
            end else if (!stall) begin
                m_instr <= rom[(m_pc >> 2) % (1 << AW)];
                m_idpc  <= m_pc;
                m_idpc4 <= m_pc + 32'd4;
                m_valid <= 1'b1;
                m_cnt   <= CW'((int'(m_cnt) + 1) % (1 << CW));
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            n_tests++;
            if ($isunknown({stall, flush, redirect_en, rst})) begin
                n_fail++;
                $display("FAIL ctrl_x: got %b expected known controls", {stall, flush, redirect_en, rst});
            end
            chk("m_if_pc",     if_pc,           m_pc);
            chk("m_imem_addr", 32'(imem_addr),  (m_pc >> 2) % (1 << AW));
            chk("m_id_instr",  id_instr,        m_instr);
            chk("m_id_pc",     id_pc,           m_idpc);
            chk("m_id_pc4",    id_pc4,          m_idpc4);
            chk("m_id_valid",  32'(id_valid),   32'(m_valid));
            chk("m_fetch_cnt", 32'(fetch_cnt),  32'(m_cnt));
        end
    end

    task automatic step(input logic s, input logic f, input logic r, input logic [31:0] t);
        stall = s;
        flush = f;
        redirect_en = r;
        redirect_target = t;
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) rom[i] = $urandom;
        rom[0] = 32'h2008_0005;
        rom[1] = 32'h2009_0003;
        rom[2] = 32'h1109_0002;

        rst = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        redirect_en = 1'b0;
        redirect_target = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        cmp_en = 1'b1;
        chk("rst_pc",    if_pc, RPC);
        chk("rst_instr", id_instr, 32'h0);
        chk("rst_valid", 32'(id_valid), 32'h0);
        chk("rst_cnt",   32'(fetch_cnt), 32'h0);

        rst = 1'b1;
        step(0, 0, 0, 32'h0);
        chk("e1_instr", id_instr, 32'h2008_0005);
        chk("e1_pc",    id_pc,    32'h0000_3000);
        chk("e1_pc4",   id_pc4,   32'h0000_3004);
        chk("e1_valid", 32'(id_valid), 32'h1);
        step(0, 0, 0, 32'h0);
        chk("e2_pc",  id_pc, 32'h0000_3004);
        chk("e2_cnt", 32'(fetch_cnt), 32'h2);
        step(0, 0, 0, 32'h0);
        chk("beq_instr", id_instr, 32'h1109_0002);
        chk("beq_ifpc",  if_pc,    32'h0000_300C);
        step(1, 0, 0, 32'h0);
        chk("stall_pc",    if_pc,    32'h0000_300C);
        chk("stall_instr", id_instr, 32'h1109_0002);
        chk("stall_cnt",   32'(fetch_cnt), 32'h3);
        step(1, 0, 1, 32'h0000_3022);
        chk("redir_pc",    if_pc,    32'h0000_3020);
        chk("redir_valid", 32'(id_valid), 32'h0);
        chk("redir_instr", id_instr, 32'h0);
        step(0, 0, 0, 32'h0);
        chk("tgt_idpc",  id_pc, 32'h0000_3020);
        chk("tgt_valid", 32'(id_valid), 32'h1);
        step(0, 1, 0, 32'h0);
        chk("flush_pc",    if_pc,    32'h0000_3028);
        chk("flush_valid", 32'(id_valid), 32'h0);
        chk("flush_instr", id_instr, 32'h0);
        chk("flush_cnt",   32'(fetch_cnt), 32'h4);
        step(0, 0, 1, 32'hFFFF_FFFC);
        chk("top_pc", if_pc, 32'hFFFF_FFFC);
        step(0, 0, 0, 32'h0);
        chk("wrap_pc",   if_pc,  32'h0000_0000);
        chk("wrap_idpc", id_pc,  32'hFFFF_FFFC);
        chk("wrap_pc4",  id_pc4, 32'h0000_0000);

        // Asynchronous reset between edges while stalled
        step(1, 0, 0, 32'h0);
        #1 rst = 1'b0;
        #1;
        chk("arst_pc",    if_pc, RPC);
        chk("arst_instr", id_instr, 32'h0);
        chk("arst_idpc",  id_pc, 32'h0);
        chk("arst_valid", 32'(id_valid), 32'h0);
        chk("arst_cnt",   32'(fetch_cnt), 32'h0);
        #1 rst = 1'b1;
        step(0, 0, 0, 32'h0);
        chk("resume_idpc",  id_pc, 32'h0000_3000);
        chk("resume_instr", id_instr, 32'h2008_0005);
        for (int i = 0; i < 14; i++) step(0, 0, 0, 32'h0);
        chk("cnt15", 32'(fetch_cnt), 32'hF);
        step(0, 0, 0, 32'h0);
        chk("cnt_wrap", 32'(fetch_cnt), 32'h0);
        chk("cnt_wrap_idpc", id_pc, 32'h0000_303C);

        for (int i = 0; i < 3000; i++) begin
            logic [31:0] t;
            t = ($urandom % 8 == 0) ? (32'hFFFF_FFF0 | ($urandom % 16))
                                    : (RPC + ($urandom % 8192));
            step(($urandom % 4) == 0, ($urandom % 10) == 0, ($urandom % 10) == 0, t);
            if ($urandom % 300 == 0) begin
                #1 rst = 1'b0;
                #1 rst = 1'b1;
            end
        end

        stall = 1'b0;
        flush = 1'b0;
        redirect_en = 1'b0;
        @(negedge clk);
        #1 cmp_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
